usb_dir_scheduler: RTL

- Sequences the FX3 slave-FIFO stream engine by choosing the transfer direction (data_dir) and issuing one burst at a time.
- Directions are host->DA (rx, data_dir=0) and FPGA->host (tx, data_dir=1).
- Arbitrates between the two directions with starvation priority for the DA FIFO and a run-length fairness limit.
- Inserts bus turnaround idle cycles and watches each burst with a timeout.

---
 rtl/usb_dir_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/usb_dir_scheduler.sv
// Direction arbiter and burst sequencer for the FX3 slave-FIFO stream engine.
// Picks rx (host->DA) or tx (FPGA->host), inserts turnaround idles and watches each burst.
module usb_dir_scheduler #(
    parameter int FIFO_AW     = 12,
    parameter int BURST_WORDS = 1024,
    parameter int LOW_WM      = 1024,
    parameter int TURN_CYC    = 4,
    parameter int MAX_RUN     = 4,
    parameter int TIMEOUT     = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               rx_avail,
    input  logic               tx_space,
    input  logic               tx_pending,
    input  logic [FIFO_AW-1:0] fifo_wrusedw,
    input  logic               fifo_wrfull,
    input  logic               burst_done,
    input  logic               clr_err,
    output logic               data_dir,
    output logic               burst_start,
    output logic               busy,
    output logic               timeout_err,
    output logic [15:0]        rx_burst_cnt,
    output logic [15:0]        tx_burst_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TURN  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_BUSY  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int TNW = $clog2(TURN_CYC + 1);
    localparam int RW  = $clog2(MAX_RUN + 1);

    localparam logic [FIFO_AW:0] FULL_LVL  = {1'b0, {FIFO_AW{1'b1}}};
    localparam logic [FIFO_AW:0] BURST_LVL = (FIFO_AW + 1)'(BURST_WORDS);
    localparam logic [FIFO_AW:0] LOW_LVL   = (FIFO_AW + 1)'(LOW_WM);
    localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TNW-1:0]   TURN_LOAD = TNW'(TURN_CYC - 1);
    localparam logic [RW-1:0]    RUN_MAX   = RW'(MAX_RUN);

    logic [2:0]       state;
    logic [TW-1:0]    tmo_tmr;
    logic [TNW-1:0]   turn_tmr;
    logic [RW-1:0]    run_cnt;
    logic             last_dir;
    logic             has_last;

    logic [FIFO_AW:0] free_lvl;
    logic             rx_elig;
    logic             tx_elig;
    logic             pick;

    // Free space is computed one bit wider so the subtraction can never wrap.
    assign free_lvl = FULL_LVL - {1'b0, fifo_wrusedw};
    assign rx_elig  = rx_avail & ~fifo_wrfull & (free_lvl >= BURST_LVL);
    assign tx_elig  = tx_space & tx_pending;

    always_comb begin
        pick = data_dir;
        if (rx_elig && !tx_elig)
            pick = 1'b0;
        else if (tx_elig && !rx_elig)
            pick = 1'b1;
        else if ({1'b0, fifo_wrusedw} < LOW_LVL)
            pick = 1'b0;
        else if (run_cnt >= RUN_MAX)
            pick = ~data_dir;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            data_dir     <= 1'b0;
            burst_start  <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            rx_burst_cnt <= 16'd0;
            tx_burst_cnt <= 16'd0;
            tmo_tmr      <= '0;
            turn_tmr     <= '0;
            run_cnt      <= '0;
            last_dir     <= 1'b0;
            has_last     <= 1'b0;
        end else begin
            burst_start <= 1'b0;
            // A timeout raised below overrides this clear on the same edge.
            if (clr_err)
                timeout_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (enable && (rx_elig || tx_elig)) begin
                        busy <= 1'b1;
                        if (pick == data_dir) begin
                            state <= S_START;
                        end else begin
                            data_dir <= pick;
                            turn_tmr <= TURN_LOAD;
                            state    <= S_TURN;
                        end
                    end
                end
                S_TURN: begin
                    if (turn_tmr == '0)
                        state <= S_START;
                    else
                        turn_tmr <= turn_tmr - TNW'(1);
                end
                S_START: begin
                    burst_start <= 1'b1;
                    tmo_tmr     <= '0;
                    state       <= S_BUSY;
                end
                S_BUSY: begin
                    if (burst_done) begin
                        if (data_dir)
                            tx_burst_cnt <= tx_burst_cnt + 16'd1;
                        else
                            rx_burst_cnt <= rx_burst_cnt + 16'd1;
                        if (has_last && (last_dir == data_dir)) begin
                            if (run_cnt < RUN_MAX)
                                run_cnt <= run_cnt + RW'(1);
                        end else begin
                            run_cnt <= RW'(1);
                        end
                        last_dir <= data_dir;
                        has_last <= 1'b1;
                        state    <= S_GAP;
                    end else if (tmo_tmr == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_GAP;
                    end else begin
                        tmo_tmr <= tmo_tmr + TW'(1);
                    end
                end
                S_GAP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
